alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters: req0 is the execute stage, req1 is the branch/address unit.
- Each requester uses a valid/ready handshake. The arbiter drives the ALU from the granted request and captures the result in a one-deep output register.
- The result is returned on one response bus, tagged with the requester id.
- Round-robin fairness: neither requester can be starved while the other holds valid high continuously.

---
 rtl/alu_arbiter_pkg.sv | 29 ++
 rtl/alu_arbiter_rr.sv | 49 ++++
 rtl/alu_arbiter.sv | 95 +++++++++
 tb/tb_alu_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared constants and types for the ALU arbiter slice.
//   XLEN      : datapath width
//   OP_W      : ALU operation code width
//   REQ_ID_W  : width of the requester id on the response bus
//   req_id_e  : requester ids (execute stage, branch/address unit)
//   ALU_*     : ALU operation codes
package alu_arbiter_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned REQ_ID_W = 1;

  typedef enum logic [REQ_ID_W-1:0] {
    REQ_EXEC   = 1'b0,
    REQ_BRANCH = 1'b1
  } req_id_e;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'd9;

endpackage

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter2: two-way round-robin grant logic with a priority pointer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : a grant may be issued this cycle
//   valid0/1     : requests from requester 0 / 1
//   grant0/1     : one-hot (or zero) grant, combinational
//   grant_id     : id of the granted requester (0 when no grant)
//   grant_any    : some requester is granted this cycle
module rr_arbiter2
  import alu_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                valid0,
  input  logic                valid1,
  output logic                grant0,
  output logic                grant1,
  output logic [REQ_ID_W-1:0] grant_id,
  output logic                grant_any
);

  req_id_e ptr;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (en) begin
      if (valid0 && valid1) begin
        grant0 = (ptr == REQ_EXEC);
        grant1 = (ptr == REQ_BRANCH);
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
    grant_any = grant0 | grant1;
    grant_id  = grant1 ? REQ_BRANCH : REQ_EXEC;
  end

  // The pointer only moves on contended grants, and then favours the loser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= REQ_EXEC;
    end else if (en && valid0 && valid1) begin
      ptr <= grant0 ? REQ_BRANCH : REQ_EXEC;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the execute stage
// (requester 0) and the branch/address unit (requester 1), with a one-deep
// registered response tagged by requester id.
//   reqN_valid/ready, reqN_in_0/1, reqN_op, reqN_inv_zero : requester N
//   alu_in_0/1, alu_operation, alu_inv_zero               : to the ALU
//   alu_out, alu_zero                                     : from the ALU
//   resp_valid/ready, resp_id, resp_out, resp_zero        : response bus
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_in_0,
  input  logic [XLEN-1:0] req0_in_1,
  input  logic [OP_W-1:0] req0_op,
  input  logic            req0_inv_zero,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_in_0,
  input  logic [XLEN-1:0] req1_in_1,
  input  logic [OP_W-1:0] req1_op,
  input  logic            req1_inv_zero,
  output logic [XLEN-1:0] alu_in_0,
  output logic [XLEN-1:0] alu_in_1,
  output logic [OP_W-1:0] alu_operation,
  output logic            alu_inv_zero,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [XLEN-1:0] resp_out,
  output logic            resp_zero
);

  logic                slot_free;
  logic                grant_en;
  logic                grant0;
  logic                grant1;
  logic                grant_any;
  logic [REQ_ID_W-1:0] grant_id;

  assign slot_free = !resp_valid || resp_ready;
  // rst_n gates the grant so both readies read 0 throughout reset.
  assign grant_en  = slot_free && rst_n;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (grant_en),
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .grant0    (grant0),
    .grant1    (grant1),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_in_0      = req0_in_0;
    alu_in_1      = req0_in_1;
    alu_operation = req0_op;
    alu_inv_zero  = req0_inv_zero;
    if (grant1) begin
      alu_in_0      = req1_in_0;
      alu_in_1      = req1_in_1;
      alu_operation = req1_op;
      alu_inv_zero  = req1_inv_zero;
    end
  end

  // resp_valid is the EMPTY/FULL state; a grant wins over a drain so that
  // back-to-back operations keep the register full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_out   <= '0;
      resp_zero  <= 1'b0;
    end else if (grant_any) begin
      resp_valid <= 1'b1;
      resp_id    <= grant_id;
      resp_out   <= alu_out;
      resp_zero  <= alu_zero;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            req0_valid, req0_ready, req0_inv_zero;
  logic [XLEN-1:0] req0_in_0, req0_in_1;
  logic [OP_W-1:0] req0_op;
  logic            req1_valid, req1_ready, req1_inv_zero;
  logic [XLEN-1:0] req1_in_0, req1_in_1;
  logic [OP_W-1:0] req1_op;
  logic [XLEN-1:0] alu_in_0, alu_in_1, alu_out;
  logic [OP_W-1:0] alu_operation;
  logic            alu_inv_zero, alu_zero;
  logic            resp_valid, resp_ready, resp_id, resp_zero;
  logic [XLEN-1:0] resp_out;

  int unsigned n_cmp;
  int unsigned n_bad;

  alu_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_in_0     (req0_in_0),
    .req0_in_1     (req0_in_1),
    .req0_op       (req0_op),
    .req0_inv_zero (req0_inv_zero),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_in_0     (req1_in_0),
    .req1_in_1     (req1_in_1),
    .req1_op       (req1_op),
    .req1_inv_zero (req1_inv_zero),
    .alu_in_0      (alu_in_0),
    .alu_in_1      (alu_in_1),
    .alu_operation (alu_operation),
    .alu_inv_zero  (alu_inv_zero),
    .alu_out       (alu_out),
    .alu_zero      (alu_zero),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_out      (resp_out),
    .resp_zero     (resp_zero)
  );

  // Stand-in for the shared ALU living in the parent.
  always_comb begin
    case (alu_operation)
      ALU_ADD:  alu_out = alu_in_0 + alu_in_1;
      ALU_SUB:  alu_out = alu_in_0 - alu_in_1;
      ALU_AND:  alu_out = alu_in_0 & alu_in_1;
      ALU_OR:   alu_out = alu_in_0 | alu_in_1;
      ALU_XOR:  alu_out = alu_in_0 ^ alu_in_1;
      ALU_SLL:  alu_out = alu_in_0 << alu_in_1[4:0];
      ALU_SRL:  alu_out = alu_in_0 >> alu_in_1[4:0];
      ALU_SRA:  alu_out = $unsigned($signed(alu_in_0) >>> alu_in_1[4:0]);
      ALU_SLT:  alu_out = {31'd0, $signed(alu_in_0) < $signed(alu_in_1)};
      ALU_SLTU: alu_out = {31'd0, alu_in_0 < alu_in_1};
      default:  alu_out = '0;
    endcase
    alu_zero = (alu_out == '0) ^ alu_inv_zero;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [3:0]  op0;
    logic [31:0] a0, b0;
    logic        iz0;
    logic        v1;
    logic [3:0]  op1;
    logic [31:0] a1, b1;
    logic        iz1;
    logic        rr;
    logic        r0, r1;
    logic        rv, id;
    logic [31:0] out;
    logic        z;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v0, logic [3:0] op0, logic [31:0] a0, logic [31:0] b0,
                              logic iz0, logic v1, logic [3:0] op1, logic [31:0] a1,
                              logic [31:0] b1, logic iz1, logic rr, logic r0, logic r1,
                              logic rv, logic id, logic [31:0] out, logic z);
    vec_t v;
    v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0; v.iz0 = iz0;
    v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1; v.iz1 = iz1;
    v.rr = rr; v.r0 = r0; v.r1 = r1; v.rv = rv; v.id = id; v.out = out; v.z = z;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req0_valid = v.v0; req0_op = v.op0; req0_in_0 = v.a0; req0_in_1 = v.b0; req0_inv_zero = v.iz0;
    req1_valid = v.v1; req1_op = v.op1; req1_in_0 = v.a1; req1_in_1 = v.b1; req1_inv_zero = v.iz1;
    resp_ready = v.rr;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    // Columns: req0 {v op a b iz} | req1 {v op a b iz} | resp_ready |
    //          expected ready0 ready1 | after edge: resp_valid id out zero
    vecs.push_back(mk(1, ALU_ADD, 5,  3,  0,  0, ALU_ADD, 0, 0, 0,  1,  1, 0,  1, 0, 8,  0));
    vecs.push_back(mk(0, ALU_ADD, 0,  0,  0,  1, ALU_SUB, 7, 7, 1,  1,  0, 1,  1, 1, 0,  0));
    vecs.push_back(mk(0, ALU_ADD, 0,  0,  0,  1, ALU_SUB, 7, 7, 0,  1,  0, 1,  1, 1, 0,  1));
    vecs.push_back(mk(0, ALU_ADD, 0,  0,  0,  0, ALU_ADD, 0, 0, 0,  1,  0, 0,  0, 1, 0,  1));
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(mk(1, ALU_XOR, 32'hF0, 32'h0F, 0,  1, ALU_OR, 1, 2, 0,  1,  1, 0,  1, 0, 32'hFF, 0));
      vecs.push_back(mk(1, ALU_XOR, 32'hF0, 32'h0F, 0,  1, ALU_OR, 1, 2, 0,  1,  0, 1,  1, 1, 3,      0));
    end
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, ALU_ADD, 10, 20, 0,  0, ALU_ADD, 0, 0, 0,  0,  0, 0,  1, 1, 3,  0));
    vecs.push_back(mk(1, ALU_ADD, 10, 20, 0,  0, ALU_ADD, 0, 0, 0,  1,  1, 0,  1, 0, 30, 0));
    vecs.push_back(mk(1, ALU_ADD, 1,  1,  0,  0, ALU_ADD, 0, 0, 0,  1,  1, 0,  1, 0, 2,  0));
    vecs.push_back(mk(0, ALU_ADD, 0,  0,  0,  0, ALU_ADD, 0, 0, 0,  0,  0, 0,  1, 0, 2,  0));
    vecs.push_back(mk(0, ALU_ADD, 0,  0,  0,  0, ALU_ADD, 0, 0, 0,  1,  0, 0,  0, 0, 2,  0));
    vecs.push_back(mk(0, ALU_ADD, 0,  0,  0,  1, ALU_ADD, 4, 4, 0,  1,  0, 1,  1, 1, 8,  0));
    vecs.push_back(mk(1, ALU_ADD, 1,  2,  0,  1, ALU_ADD, 3, 4, 0,  1,  1, 0,  1, 0, 3,  0));
    vecs.push_back(mk(1, ALU_ADD, 1,  2,  0,  1, ALU_ADD, 3, 4, 0,  1,  0, 1,  1, 1, 7,  0));
    vecs.push_back(mk(0, ALU_ADD, 0,  0,  0,  0, ALU_ADD, 0, 0, 0,  1,  0, 0,  0, 1, 7,  0));
    vecs.push_back(mk(1, 4'hF,    9,  9,  0,  0, ALU_ADD, 0, 0, 0,  1,  1, 0,  1, 0, 0,  1));
    vecs.push_back(mk(0, ALU_ADD, 0,  0,  0,  0, ALU_ADD, 0, 0, 0,  1,  0, 0,  0, 0, 0,  1));

    // Reset state, with both requesters asking to confirm readies stay low.
    rst_n = 1'b0;
    drive(mk(1, ALU_ADD, 1, 1, 0, 1, ALU_ADD, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    #12;
    check("reset resp_valid", {31'd0, resp_valid}, 0);
    check("reset resp_id",    {31'd0, resp_id},    0);
    check("reset resp_out",   resp_out,            0);
    check("reset resp_zero",  {31'd0, resp_zero},  0);
    check("reset ready0",     {31'd0, req0_ready}, 0);
    check("reset ready1",     {31'd0, req1_ready}, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      vec_t v;
      logic [31:0] ea0, eb0;
      logic [3:0]  eop;
      logic        eiz;
      v = vecs[i];
      @(negedge clk);
      drive(v);
      #1;
      ea0 = v.r1 ? v.a1 : v.a0;
      eb0 = v.r1 ? v.b1 : v.b0;
      eop = v.r1 ? v.op1 : v.op0;
      eiz = v.r1 ? v.iz1 : v.iz0;
      check($sformatf("v%0d ready0", i), {31'd0, req0_ready}, {31'd0, v.r0});
      check($sformatf("v%0d ready1", i), {31'd0, req1_ready}, {31'd0, v.r1});
      check($sformatf("v%0d alu_in_0", i), alu_in_0, ea0);
      check($sformatf("v%0d alu_in_1", i), alu_in_1, eb0);
      check($sformatf("v%0d alu_op", i), {28'd0, alu_operation}, {28'd0, eop});
      check($sformatf("v%0d alu_inv_zero", i), {31'd0, alu_inv_zero}, {31'd0, eiz});
      @(posedge clk);
      #1;
      check($sformatf("v%0d resp_valid", i), {31'd0, resp_valid}, {31'd0, v.rv});
      check($sformatf("v%0d resp_id", i), {31'd0, resp_id}, {31'd0, v.id});
      check($sformatf("v%0d resp_out", i), resp_out, v.out);
      check($sformatf("v%0d resp_zero", i), {31'd0, resp_zero}, {31'd0, v.z});
    end

    // Throughput: eight back-to-back ADDs (i,i), one response per cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(mk(1, ALU_ADD, i, i, 0, 0, ALU_ADD, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      #1;
      check($sformatf("tp%0d ready0", i), {31'd0, req0_ready}, 1);
      @(posedge clk);
      #1;
      check($sformatf("tp%0d resp_valid", i), {31'd0, resp_valid}, 1);
      check($sformatf("tp%0d resp_out", i), resp_out, 2 * i);
    end

    // Reset mid-flight: contended grant to 0 moves the pointer to 1,
    // then an asynchronous reset must clear everything with no clock edge.
    @(negedge clk);
    drive(mk(1, ALU_ADD, 5, 3, 0, 1, ALU_ADD, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("mid resp_valid before", {31'd0, resp_valid}, 1);
    check("mid resp_out before", resp_out, 8);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid resp_valid", {31'd0, resp_valid}, 0);
    check("mid resp_out",   resp_out,            0);
    check("mid ready0",     {31'd0, req0_ready}, 0);
    check("mid ready1",     {31'd0, req1_ready}, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post reset no resp", {31'd0, resp_valid}, 0);
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("post reset ptr ready0", {31'd0, req0_ready}, 1);
    check("post reset ptr ready1", {31'd0, req1_ready}, 0);
    @(posedge clk);
    #1;
    check("post reset resp_id", {31'd0, resp_id}, 0);
    check("post reset resp_out", resp_out, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
